// File: rtl/rotating_square_ctrl.sv
// Position sequencer for the circulating-square animation on a 4-digit display.
// Steps pos (0-7) automatically from a prescaler or manually from a button, with step/lap pulses.
module rotating_square_ctrl #(
   parameter int TICK_MAX = 25_000_000,
   parameter int CNT_W    = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       cw,
   input  logic [1:0] speed,
   input  logic       step_btn,
   output logic [2:0] pos,
   output logic       tick,
   output logic       lap
);

   localparam logic [CNT_W-1:0] TICK_L = CNT_W'(TICK_MAX);
   localparam logic [CNT_W-1:0] ONE_L  = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_btn_q;
   logic [2:0]       r_pos;
   logic             r_tick;
   logic             r_lap;

   logic [CNT_W-1:0] w_lim;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_step_req;
   logic [2:0]       w_pos_nxt;
   logic             w_wrap;

   // Prescaler limit, step request and next position
   always_comb begin
      w_lim      = (TICK_L >> speed) - ONE_L;
      w_cnt_nxt  = r_cnt;
      w_step_req = 1'b0;
      w_pos_nxt  = r_pos;
      w_wrap     = 1'b0;
      if (en) begin
         // >= so that a mid-count speed increase steps immediately
         if (r_cnt >= w_lim) begin
            w_cnt_nxt  = '0;
            w_step_req = 1'b1;
         end else begin
            w_cnt_nxt  = r_cnt + ONE_L;
         end
      end else begin
         w_step_req = step_btn & ~r_btn_q;
      end
      if (cw) begin
         w_pos_nxt = r_pos + 3'd1;
         w_wrap    = (r_pos == 3'd7);
      end else begin
         w_pos_nxt = r_pos - 3'd1;
         w_wrap    = (r_pos == 3'd0);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_btn_q <= 1'b0;
         r_pos   <= 3'd0;
         r_tick  <= 1'b0;
         r_lap   <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_btn_q <= step_btn;
         r_tick  <= w_step_req;
         r_lap   <= w_step_req & w_wrap;
         if (w_step_req) begin
            r_pos <= w_pos_nxt;
         end else begin
            r_pos <= r_pos;
         end
      end
   end

   assign pos  = r_pos;
   assign tick = r_tick;
   assign lap  = r_lap;

endmodule

// File: tb/tb_rotating_square_ctrl.sv
// Directed self-checking bench for rotating_square_ctrl with an 8-cycle base period.
module tb_rotating_square_ctrl;

   logic       clk;
   logic       reset;
   logic       en;
   logic       cw;
   logic [1:0] speed;
   logic       step_btn;
   logic [2:0] pos;
   logic       tick;
   logic       lap;

   int n_checks;
   int n_fail;
   int cyc;

   rotating_square_ctrl #(.TICK_MAX(8), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .cw       (cw),
      .speed    (speed),
      .step_btn (step_btn),
      .pos      (pos),
      .tick     (tick),
      .lap      (lap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // advance until tick, bounded; returns clock edges consumed
   task automatic wait_tick(input string tag, input int budget, output int cycles);
      cycles = 0;
      do begin
         step_clk();
         cycles++;
      end while (!tick && cycles < budget);
      check_val({tag, "_tick_seen"}, int'(tick), 1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      en       = 1'b0;
      cw       = 1'b1;
      speed    = 2'd0;
      step_btn = 1'b0;
      step_clk();
      step_clk();
      check_val("rst_pos", int'(pos), 0);
      check_val("rst_tick", int'(tick), 0);
      check_val("rst_lap", int'(lap), 0);

      // clockwise full lap, period 8
      reset = 1'b0;
      en    = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wait_tick("cw", 20, cyc);
         check_val("cw_period", cyc, 8);
         check_val("cw_pos", int'(pos), i % 8);
         check_val("cw_lap", int'(lap), (i == 8) ? 1 : 0);
      end
      step_clk();
      check_val("tick_one_cycle", int'(tick), 0);
      check_val("lap_one_cycle", int'(lap), 0);

      // counter-clockwise from pos 0 (7 cycles of period remain)
      cw = 1'b0;
      wait_tick("ccw0", 20, cyc);
      check_val("ccw0_period", cyc, 7);
      check_val("ccw0_pos", int'(pos), 7);
      check_val("ccw0_lap", int'(lap), 1);
      for (int p = 6; p >= 4; p--) begin
         wait_tick("ccw", 20, cyc);
         check_val("ccw_period", cyc, 8);
         check_val("ccw_pos", int'(pos), p);
         check_val("ccw_lap", int'(lap), 0);
      end

      // speed jump at cnt=5
      for (int i = 0; i < 5; i++) step_clk();
      check_val("pre_speed_tick", int'(tick), 0);
      speed = 2'd3;
      wait_tick("spd3_first", 20, cyc);
      check_val("spd3_first_lat", cyc, 1);
      check_val("spd3_first_pos", int'(pos), 3);
      for (int p = 2; p >= -1; p--) begin
         wait_tick("spd3", 20, cyc);
         check_val("spd3_period", cyc, 1);
         check_val("spd3_pos", int'(pos), (p + 8) % 8);
         check_val("spd3_lap", int'(lap), (p == -1) ? 1 : 0);
      end
      speed = 2'd0;
      wait_tick("spd0", 20, cyc);
      check_val("spd0_period", cyc, 8);
      check_val("spd0_pos", int'(pos), 6);

      // pause at cnt=4 for 10 cycles
      cw = 1'b1;
      for (int i = 0; i < 4; i++) step_clk();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step_clk();
         check_val("pause_tick", int'(tick), 0);
      end
      check_val("pause_pos", int'(pos), 6);
      en = 1'b1;
      wait_tick("resume", 20, cyc);
      check_val("resume_lat", cyc, 4);
      check_val("resume_pos", int'(pos), 7);

      // manual step, button held 20 cycles
      en       = 1'b0;
      step_btn = 1'b1;
      wait_tick("man1", 5, cyc);
      check_val("man1_lat", cyc, 1);
      check_val("man1_pos", int'(pos), 0);
      check_val("man1_lap", int'(lap), 1);
      for (int i = 0; i < 19; i++) begin
         step_clk();
         check_val("man_hold_tick", int'(tick), 0);
      end
      check_val("man_hold_pos", int'(pos), 0);
      step_btn = 1'b0;
      step_clk();
      step_clk();
      step_btn = 1'b1;
      wait_tick("man2", 5, cyc);
      check_val("man2_lat", cyc, 1);
      check_val("man2_pos", int'(pos), 1);
      check_val("man2_lap", int'(lap), 0);
      step_btn = 1'b0;
      step_clk();
      step_clk();

      // en rises together with a button edge: edge ignored, counter starts
      en       = 1'b1;
      step_btn = 1'b1;
      step_clk();
      check_val("en_btn_tick", int'(tick), 0);
      check_val("en_btn_pos", int'(pos), 1);
      wait_tick("en_btn", 20, cyc);
      check_val("en_btn_period", cyc, 7);
      check_val("en_btn_auto_pos", int'(pos), 2);
      step_btn = 1'b0;

      // one-cycle reset mid-count
      for (int i = 0; i < 3; i++) step_clk();
      reset = 1'b1;
      step_clk();
      reset = 1'b0;
      check_val("mid_rst_pos", int'(pos), 0);
      check_val("mid_rst_tick", int'(tick), 0);
      check_val("mid_rst_lap", int'(lap), 0);
      wait_tick("post_rst", 20, cyc);
      check_val("post_rst_period", cyc, 8);
      check_val("post_rst_pos", int'(pos), 1);
      check_val("post_rst_lap", int'(lap), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
